dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port A is the core load/store path, port B is the debug/DMA loader.
- Uses round-robin arbitration with a registered grant owner. The arbiter drives the memory's write strobe, read strobe, address and write data.
- Returns registered read data with a one-cycle valid pulse. Flags out-of-range word indices and suppresses the memory access for them.

---
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (A)
// and the debug/DMA loader (B). Read data and errors return one cycle after grant.
module dmem_arbiter #(
  parameter int DEPTH = 64,
  parameter int IW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_t;

  localparam logic [IW:0] DEPTH_LIM = DEPTH[IW:0];

  owner_t          owner;
  owner_t          owner_nxt;
  owner_t          rr_last;
  logic [31:0]     rdata_q;
  logic            rsp_port;
  logic            rsp_valid;
  logic            rsp_err;

  logic            serving;
  logic            sel_we;
  logic [IW-1:0]   sel_idx;
  logic [31:0]     sel_wdata;
  logic            in_range;
  logic            rsp_load;
  logic            elig_a;
  logic            elig_b;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{a_addr[31:IW], b_addr[31:IW]};

  // Serve stage: mux the owning port's fields onto the memory bus.
  always_comb begin
    sel_we    = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    case (owner)
      OWN_A: begin
        sel_we    = a_we;
        sel_idx   = a_addr[IW-1:0];
        sel_wdata = a_wdata;
      end
      OWN_B: begin
        sel_we    = b_we;
        sel_idx   = b_addr[IW-1:0];
        sel_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  assign serving   = (owner != OWN_NONE);
  assign in_range  = serving && ({1'b0, sel_idx} < DEPTH_LIM);
  assign rsp_load  = serving && (!sel_we || !in_range);

  assign a_gnt     = (owner == OWN_A);
  assign b_gnt     = (owner == OWN_B);
  assign mem_we    = serving & sel_we & in_range;
  assign mem_re    = serving & ~sel_we & in_range;
  assign mem_addr  = {{(32-IW){1'b0}}, sel_idx};
  assign mem_wdata = sel_wdata;

  // The port granted this cycle may not be picked again for the next one.
  always_comb begin
    elig_a = a_req && (owner != OWN_A);
    elig_b = b_req && (owner != OWN_B);
    if (elig_a && elig_b)
      owner_nxt = (rr_last == OWN_A) ? OWN_B : OWN_A;
    else if (elig_a)
      owner_nxt = OWN_A;
    else if (elig_b)
      owner_nxt = OWN_B;
    else
      owner_nxt = OWN_NONE;
  end

  // Response stage: captured on the edge that closes the serve cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      rr_last   <= OWN_B;
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_err   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      owner     <= owner_nxt;
      rsp_valid <= rsp_load;
      if (serving)
        rr_last <= owner;
      if (rsp_load) begin
        rsp_port <= (owner == OWN_B);
        rsp_err  <= ~in_range;
        rdata_q  <= in_range ? mem_rdata : 32'h0;
      end
    end
  end

  assign a_rvalid = rsp_valid & ~rsp_port;
  assign b_rvalid = rsp_valid & rsp_port;
  assign a_err    = a_rvalid & rsp_err;
  assign b_err    = b_rvalid & rsp_err;
  assign a_rdata  = a_rvalid ? rdata_q : 32'h0;
  assign b_rdata  = b_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a transaction-level
// reference model of arbitration, memory contents and responses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  int          n_checks = 0;
  int          n_fail = 0;

  // reference model: 0 = nobody, 1 = port A, 2 = port B
  int          own_m, rr_m, rp_m;
  logic        rv_m, re_m;
  logic [31:0] rd_m;
  logic        a_seen, b_seen;

  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? mem[mem_addr[7:0]] : 32'h0;

  dmem_arbiter #(.DEPTH(64), .IW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own_m = 0; rr_m = 2; rp_m = 0; rv_m = 1'b0; re_m = 1'b0; rd_m = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all outputs against the model for this cycle, then advance the model
  // across the coming clock edge.
  task automatic eval();
    logic        sw, inr, ea, eb, av, bv;
    logic [31:0] sa, sd;
    logic [7:0]  idx;
    int          nxt;
    #1;
    if (!rst_n) model_reset();
    sw = 1'b0; sa = 32'h0; sd = 32'h0;
    if (own_m == 1) begin sw = a_we; sa = a_addr; sd = a_wdata; end
    if (own_m == 2) begin sw = b_we; sa = b_addr; sd = b_wdata; end
    idx = sa[7:0];
    inr = (own_m != 0) && (idx < 8'd64);
    av  = rv_m && (rp_m == 1);
    bv  = rv_m && (rp_m == 2);
    chk("a_gnt",     32'(a_gnt),    32'(own_m == 1));
    chk("b_gnt",     32'(b_gnt),    32'(own_m == 2));
    chk("mem_we",    32'(mem_we),   32'(inr && sw));
    chk("mem_re",    32'(mem_re),   32'(inr && !sw));
    chk("mem_addr",  mem_addr,      {24'h0, idx});
    chk("mem_wdata", mem_wdata,     sd);
    chk("a_rvalid",  32'(a_rvalid), 32'(av));
    chk("a_err",     32'(a_err),    32'(av && re_m));
    chk("a_rdata",   a_rdata,       av ? rd_m : 32'h0);
    chk("b_rvalid",  32'(b_rvalid), 32'(bv));
    chk("b_err",     32'(b_err),    32'(bv && re_m));
    chk("b_rdata",   b_rdata,       bv ? rd_m : 32'h0);
    a_seen = a_gnt;
    b_seen = b_gnt;
    if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
    if (rst_n) begin
      ea = a_req && (own_m != 1);
      eb = b_req && (own_m != 2);
      if (ea && eb)      nxt = (rr_m == 1) ? 2 : 1;
      else if (ea)       nxt = 1;
      else if (eb)       nxt = 2;
      else               nxt = 0;
      rv_m = 1'b0;
      if (own_m != 0) begin
        rr_m = own_m;
        if (!sw || !inr) begin
          rv_m = 1'b1; rp_m = own_m;
          rd_m = inr ? ref_mem[idx] : 32'h0;
          re_m = !inr;
        end else begin
          ref_mem[idx] = sd;
        end
      end
      own_m = nxt;
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  // Requester behaviour: hold a request until granted, then maybe issue another.
  task automatic gen(inout logic req, inout logic we, inout logic [31:0] ad,
                     inout logic [31:0] d, input logic seen);
    logic [31:0] idx;
    if (!req || seen) begin
      if ($urandom_range(0, 9) < 6) begin
        idx = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 255))
                                          : 32'($urandom_range(0, 15));
        req = 1'b1;
        we  = $urandom_range(0, 1) == 1;
        ad  = ($urandom() & 32'hFFFF_FF00) | idx;
        d   = $urandom();
      end else begin
        req = 1'b0;
      end
    end
  endtask

  task automatic drain();
    repeat (6) begin
      tick();
      if (a_seen) a_req = 1'b0;
      if (b_seen) b_req = 1'b0;
      eval();
    end
  endtask

  initial begin
    int          ga, gb;
    logic [31:0] v, save6;
    for (int i = 0; i < 256; i++) begin
      v = $urandom();
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    a_seen = 1'b0; b_seen = 1'b0;
    rst_n = 1'b0;
    model_reset();
    tick(); eval();
    tick(); eval();

    // read of a preloaded word right after reset
    tick(); rst_n = 1'b1; set_a(1, 0, 5, 0); eval();
    tick(); eval();
    chk("t1_gnt", 32'(a_gnt), 32'd1);
    chk("t1_re", 32'(mem_re), 32'd1);
    chk("t1_addr", mem_addr, 32'd5);
    tick(); a_req = 1'b0; eval();
    chk("t1_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);

    // both ports saturating: grants alternate
    tick(); set_a(1, 0, 1, 0); set_b(1, 0, 2, 0); eval();
    ga = 0; gb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_seen) a_addr = 32'(i);
      if (b_seen) b_addr = 32'(i + 20);
      eval();
      ga += int'(a_gnt);
      gb += int'(b_gnt);
    end
    chk("t2_a_grants", 32'(ga), 32'd4);
    chk("t2_b_grants", 32'(gb), 32'd4);
    drain();

    // B write followed by A read of the same word
    tick(); set_b(1, 1, 10, 32'h1234); eval();
    tick(); set_a(1, 0, 10, 0); eval();
    chk("t3_b_gnt", 32'(b_gnt), 32'd1);
    chk("t3_we", 32'(mem_we), 32'd1);
    tick(); b_req = 1'b0; eval();
    chk("t3_a_gnt", 32'(a_gnt), 32'd1);
    chk("t3_we_off", 32'(mem_we), 32'd0);
    tick(); a_req = 1'b0; eval();
    chk("t3_rdata", a_rdata, 32'h1234);

    // out-of-range write is flagged and suppressed
    save6 = mem[6];
    tick(); set_a(1, 1, 70, 32'hCAFE_F00D); eval();
    tick(); eval();
    chk("t4_gnt", 32'(a_gnt), 32'd1);
    chk("t4_we", 32'(mem_we), 32'd0);
    tick(); a_req = 1'b0; eval();
    chk("t4_err", 32'(a_err), 32'd1);
    chk("t4_rdata", a_rdata, 32'h0);
    chk("t4_mem6", mem[6], save6);
    chk("t4_mem70", mem[70], ref_mem[70]);

    // reset lands during a read grant
    tick(); set_a(1, 0, 3, 0); eval();
    tick(); eval();
    #1 rst_n = 1'b0;
    eval();
    chk("t5_gnt_rst", 32'(a_gnt), 32'd0);
    a_req = 1'b0;
    tick(); eval();
    tick(); rst_n = 1'b1; set_a(1, 0, 4, 0); set_b(1, 0, 7, 0); eval();
    chk("t5_no_rvalid", 32'(a_rvalid), 32'd0);
    tick(); eval();
    chk("t5_tie_a", 32'(a_gnt), 32'd1);
    drain();

    // A alone requesting continuously: grant every other cycle
    tick(); set_a(1, 0, 8, 0); eval();
    ga = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_seen) a_addr = 32'(8 + i);
      eval();
      ga += int'(a_gnt);
    end
    chk("t6_a_grants", 32'(ga), 32'd5);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      gen(a_req, a_we, a_addr, a_wdata, a_seen);
      gen(b_req, b_we, b_addr, b_wdata, b_seen);
      eval();
    end
    drain();
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
